// File: rtl/hv_abist_pkg.sv
`default_nettype none
// ============================================================================
// hv_abist_pkg : shared types and constants for the HV analog BIST sequencer
// Rev 1.0
// ============================================================================
package hv_abist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEEK    = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_RELEASE = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } bist_st_e;

  // Default item windows, expressed in system clock cycles (CLK_M = clock in MHz)
  localparam int CLK_M      = 50;
  localparam int c_win_70us = 70 * CLK_M;
  localparam int c_win_1us  = 1 * CLK_M;
  localparam int c_win_4us  = 4 * CLK_M;

  localparam logic [9:0] c_adc_win_lo = 10'h1F8;
  localparam logic [9:0] c_adc_win_hi = 10'h207;

  function automatic logic in_adc_win(input logic [9:0] code);
    return (code >= c_adc_win_lo) && (code <= c_adc_win_hi);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hv_abist_seq_if.sv
`default_nettype none
// ============================================================================
// hv_abist_seq_if : register-bank / analog-side bundle of the HV BIST sequencer
// Rev 1.0
// ============================================================================
interface hv_abist_seq_if #(
  parameter int ITEM_NUM = 6,
  parameter int CNT_W    = 12,
  parameter int RETRY_W  = 2,
  parameter int SEL_W    = (ITEM_NUM > 1) ? $clog2(ITEM_NUM) : 1
);
  logic                      i_bist_en;
  logic [ITEM_NUM-1:0]       i_item_mask;
  logic [ITEM_NUM*CNT_W-1:0] i_item_win;
  logic [RETRY_W-1:0]        i_retry_num;
  logic                      i_stop_on_fail;
  logic [ITEM_NUM-1:0]       i_det;
  logic [ITEM_NUM-1:0]       o_bist_drv;
  logic [ITEM_NUM-1:0]       o_bist_pass;
  logic [ITEM_NUM-1:0]       o_bist_fail;
  logic [ITEM_NUM-1:0]       o_bist_stuck;
  logic                      o_bist_busy;
  logic                      o_bist_done;
  logic                      o_lbist_en;
  logic [SEL_W-1:0]          o_cur_item;

  modport master (
    output i_bist_en, i_item_mask, i_item_win, i_retry_num, i_stop_on_fail, i_det,
    input  o_bist_drv, o_bist_pass, o_bist_fail, o_bist_stuck,
           o_bist_busy, o_bist_done, o_lbist_en, o_cur_item
  );

  modport slave (
    input  i_bist_en, i_item_mask, i_item_win, i_retry_num, i_stop_on_fail, i_det,
    output o_bist_drv, o_bist_pass, o_bist_fail, o_bist_stuck,
           o_bist_busy, o_bist_done, o_lbist_en, o_cur_item
  );
endinterface
`default_nettype wire

// File: rtl/hv_abist_seq.sv
`default_nettype none
// ============================================================================
// hv_abist_seq : walks the enabled HV analog self-test items, pulses each
//                stimulus and grades detect assertion / release per item.
// Rev 1.0
// ============================================================================
module hv_abist_seq
  import hv_abist_pkg::*;
#(
  parameter int ITEM_NUM = 6,
  parameter int CNT_W    = 12,
  parameter int REL_TO   = 255,
  parameter int RETRY_W  = 2,
  parameter int SEL_W    = (ITEM_NUM > 1) ? $clog2(ITEM_NUM) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  hv_abist_seq_if.slave bus
);
  // One spare bit so the walk index can reach ITEM_NUM (end of list)
  localparam int IDX_W = SEL_W + 1;

  bist_st_e            r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_sel, w_sel_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [RETRY_W-1:0]  r_retry, w_retry_nxt;
  logic                r_hit, w_hit_nxt;
  logic [ITEM_NUM-1:0] r_pass, w_pass_nxt;
  logic [ITEM_NUM-1:0] r_fail, w_fail_nxt;
  logic [ITEM_NUM-1:0] r_stuck, w_stuck_nxt;
  logic [ITEM_NUM-1:0] r_drv, w_drv_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_done, w_done_nxt;
  logic                r_lbist, w_lbist_nxt;

  logic [SEL_W-1:0]    w_sel_i;
  logic [CNT_W-1:0]    w_win;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_det;
  logic                w_last;
  logic                w_hit_now;
  logic                w_item_done;

  assign w_sel_i   = r_sel[SEL_W-1:0];
  assign w_det     = bus.i_det[w_sel_i];
  assign w_win     = bus.i_item_win[int'(w_sel_i)*CNT_W +: CNT_W];
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  // Last drive cycle once cnt+1 covers the window; a zero window still drives once
  assign w_last    = ({1'b0, r_cnt} + (CNT_W+1)'(1)) >= {1'b0, w_win};
  assign w_hit_now = r_hit | w_det;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_cnt_nxt   = r_cnt;
    w_retry_nxt = r_retry;
    w_hit_nxt   = r_hit;
    w_pass_nxt  = r_pass;
    w_fail_nxt  = r_fail;
    w_stuck_nxt = r_stuck;
    w_item_done = 1'b0;
    if (!bus.i_bist_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_pass_nxt  = '0;
          w_fail_nxt  = '0;
          w_stuck_nxt = '0;
          w_sel_nxt   = '0;
          w_state_nxt = ST_SEEK;
        end
        ST_SEEK: begin
          if (r_sel == IDX_W'(ITEM_NUM)) begin
            w_state_nxt = ST_DONE;
          end else if (!bus.i_item_mask[w_sel_i]) begin
            w_sel_nxt = r_sel + IDX_W'(1);
          end else begin
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
            w_hit_nxt   = 1'b0;
            w_state_nxt = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          w_cnt_nxt = w_cnt_inc;
          w_hit_nxt = w_hit_now;
          if (w_last) begin
            w_cnt_nxt = '0;
            if (w_hit_now) begin
              w_state_nxt = ST_RELEASE;
            end else if (r_retry < bus.i_retry_num) begin
              w_retry_nxt = r_retry + RETRY_W'(1);
              w_state_nxt = ST_GAP;
            end else begin
              w_fail_nxt[w_sel_i] = 1'b1;
              w_state_nxt         = ST_RELEASE;
            end
          end
        end
        ST_GAP: begin
          w_cnt_nxt   = '0;
          w_hit_nxt   = 1'b0;
          w_state_nxt = ST_DRIVE;
        end
        ST_RELEASE: begin
          if (!w_det) begin
            if (!r_fail[w_sel_i]) w_pass_nxt[w_sel_i] = 1'b1;
            w_item_done = 1'b1;
          end else if (w_cnt_inc >= CNT_W'(REL_TO)) begin
            w_fail_nxt[w_sel_i]  = 1'b1;
            w_stuck_nxt[w_sel_i] = 1'b1;
            w_pass_nxt[w_sel_i]  = 1'b0;
            w_item_done          = 1'b1;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
          if (w_item_done) begin
            if (bus.i_stop_on_fail && w_fail_nxt[w_sel_i]) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_sel_nxt   = r_sel + IDX_W'(1);
              w_state_nxt = ST_SEEK;
            end
          end
        end
        ST_DONE:  w_state_nxt = ST_DONE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next-state view so they line up with the state
  always_comb begin
    w_drv_nxt = '0;
    if (w_state_nxt == ST_DRIVE) w_drv_nxt[w_sel_nxt[SEL_W-1:0]] = 1'b1;
    w_busy_nxt  = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_lbist_nxt = w_done_nxt && !(|w_fail_nxt);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sel   <= '0;
      r_cnt   <= '0;
      r_retry <= '0;
      r_hit   <= 1'b0;
      r_pass  <= '0;
      r_fail  <= '0;
      r_stuck <= '0;
      r_drv   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_lbist <= 1'b0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_cnt   <= w_cnt_nxt;
      r_retry <= w_retry_nxt;
      r_hit   <= w_hit_nxt;
      r_pass  <= w_pass_nxt;
      r_fail  <= w_fail_nxt;
      r_stuck <= w_stuck_nxt;
      r_drv   <= w_drv_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_lbist <= w_lbist_nxt;
    end
  end

  assign bus.o_bist_drv   = r_drv;
  assign bus.o_bist_pass  = r_pass;
  assign bus.o_bist_fail  = r_fail;
  assign bus.o_bist_stuck = r_stuck;
  assign bus.o_bist_busy  = r_busy;
  assign bus.o_bist_done  = r_done;
  assign bus.o_lbist_en   = r_lbist;
  assign bus.o_cur_item   = r_sel[SEL_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_hv_abist_seq.sv
`default_nettype none
// ============================================================================
// tb_hv_abist_seq : self-checking bench with a reactive analog responder
// Rev 1.0
// ============================================================================
module tb_hv_abist_seq;
  localparam int N  = 6;
  localparam int CW = 12;
  localparam int RW = 2;
  localparam int SW = 3;
  localparam int M_OK = 0, M_MISS = 1, M_STUCK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hv_abist_seq_if #(.ITEM_NUM(N), .CNT_W(CW), .RETRY_W(RW), .SEL_W(SW)) bus ();

  hv_abist_seq #(.ITEM_NUM(N), .CNT_W(CW), .REL_TO(255), .RETRY_W(RW), .SEL_W(SW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scenario description
  int          mode_a[N], dly_a[N], len_a[N], win_a[N];
  logic [N-1:0] mask_v;
  int          retry_v;
  bit          stop_v;

  // Expected results
  logic [N-1:0] exp_pass, exp_fail, exp_stuck;
  int           exp_cur;
  int           exp_pul[N];

  // Analog responder and drive monitor
  logic [N-1:0] prev_drv = '0;
  logic [N-1:0] drv_s;
  logic [N-1:0] det_v;
  int  t_a[N], run_a[N], gap_a[N], pulses_a[N];
  bit  seen_a[N];
  int  bad_len = 0, bad_gap = 0, multi_hot = 0, multi_chg = 0;

  always @(negedge clk) begin
    drv_s = bus.o_bist_drv;
    if ($countones(drv_s) > 1) multi_hot++;
    if ($countones(drv_s ^ prev_drv) > 1) multi_chg++;
    for (int i = 0; i < N; i++) begin
      if (!bus.i_bist_en) begin
        seen_a[i] = 1'b0; t_a[i] = 0; run_a[i] = 0; gap_a[i] = 0; pulses_a[i] = 0;
      end else if (drv_s[i] && !prev_drv[i]) begin
        if (pulses_a[i] > 0 && gap_a[i] != 1) bad_gap++;
        seen_a[i] = 1'b1; t_a[i] = 0; run_a[i] = 1;
      end else begin
        if (seen_a[i]) t_a[i]++;
        if (drv_s[i]) run_a[i]++;
        else if (prev_drv[i]) begin
          pulses_a[i]++;
          if (run_a[i] != ((win_a[i] == 0) ? 1 : win_a[i])) bad_len++;
          gap_a[i] = 1;
        end else if (pulses_a[i] > 0) gap_a[i]++;
      end
      det_v[i] = bus.i_bist_en && seen_a[i] &&
                 ((mode_a[i] == M_STUCK) ||
                  (mode_a[i] == M_OK && t_a[i] >= dly_a[i] && t_a[i] < dly_a[i] + len_a[i]));
    end
    bus.i_det = det_v;
    prev_drv  = drv_s;
  end

  // Item-level reference: each enabled item in order passes, misses or sticks
  function automatic void predict();
    exp_pass = '0; exp_fail = '0; exp_stuck = '0; exp_cur = N;
    for (int i = 0; i < N; i++) exp_pul[i] = 0;
    for (int i = 0; i < N; i++) begin
      if (!mask_v[i]) continue;
      case (mode_a[i])
        M_OK:    begin exp_pass[i] = 1'b1; exp_pul[i] = 1; end
        M_MISS:  begin exp_fail[i] = 1'b1; exp_pul[i] = retry_v + 1; end
        default: begin exp_fail[i] = 1'b1; exp_stuck[i] = 1'b1; exp_pul[i] = 1; end
      endcase
      if (stop_v && exp_fail[i]) begin
        exp_cur = i;
        break;
      end
    end
  endfunction

  function automatic void set_all(input int w, input int m, input int d, input int l);
    for (int i = 0; i < N; i++) begin
      win_a[i] = w; mode_a[i] = m; dly_a[i] = d; len_a[i] = l;
    end
    mask_v = '1; retry_v = 0; stop_v = 1'b0;
  endfunction

  task automatic start_run(input string tag);
    for (int i = 0; i < N; i++) bus.i_item_win[i*CW +: CW] = CW'(win_a[i]);
    bus.i_item_mask    = mask_v;
    bus.i_retry_num    = RW'(retry_v);
    bus.i_stop_on_fail = stop_v;
    bus.i_bist_en      = 1'b1;
    chk({tag, "_busy_pre"}, bus.o_bist_busy, 0);
    @(negedge clk); #1;
    chk({tag, "_busy_rise"}, bus.o_bist_busy, 1);
    chk({tag, "_status_clr"}, {bus.o_bist_pass, bus.o_bist_fail, bus.o_bist_stuck}, 0);
  endtask

  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (!bus.o_bist_done && cyc < 20000) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk({tag, "_done"}, bus.o_bist_done, 1);
  endtask

  task automatic check_result(input string tag);
    logic [SW-1:0] ecur;
    predict();
    ecur = exp_cur[SW-1:0];
    chk({tag, "_pass"},  bus.o_bist_pass, exp_pass);
    chk({tag, "_fail"},  bus.o_bist_fail, exp_fail);
    chk({tag, "_stuck"}, bus.o_bist_stuck, exp_stuck);
    chk({tag, "_lbist"}, bus.o_lbist_en, (exp_fail == '0));
    chk({tag, "_cur"},   bus.o_cur_item, ecur);
    chk({tag, "_busy"},  bus.o_bist_busy, 0);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_pulses%0d", tag, i), pulses_a[i], exp_pul[i]);
    chk({tag, "_pulse_len"}, bad_len, 0);
    chk({tag, "_gap"}, bad_gap, 0);
    repeat (3) begin @(negedge clk); #1; end
    chk({tag, "_done_hold"}, bus.o_bist_done, 1);
    bus.i_bist_en = 1'b0;
    @(negedge clk); #1;
    chk({tag, "_done_drop"}, {bus.o_bist_done, bus.o_lbist_en, bus.o_bist_busy}, 0);
    chk({tag, "_pass_held"}, bus.o_bist_pass, exp_pass);
  endtask

  task automatic full_run(input string tag);
    int cyc;
    start_run(tag);
    wait_done(tag, cyc);
    check_result(tag);
  endtask

  initial begin
    int cyc, k, r;
    bus.i_bist_en = 1'b0; bus.i_item_mask = '0; bus.i_item_win = '0;
    bus.i_retry_num = '0; bus.i_stop_on_fail = 1'b0;
    set_all(10, M_OK, 3, 2);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_drv",   bus.o_bist_drv, 0);
    chk("rst_pass",  bus.o_bist_pass, 0);
    chk("rst_fail",  bus.o_bist_fail, 0);
    chk("rst_stuck", bus.o_bist_stuck, 0);
    chk("rst_flags", {bus.o_bist_busy, bus.o_bist_done, bus.o_lbist_en}, 0);
    chk("rst_cur",   bus.o_cur_item, 0);
    rst = 1'b0;
    @(negedge clk); #1;

    // All items pass with the nominal detect timing
    set_all(10, M_OK, 3, 2);
    start_run("all_pass");
    wait_done("all_pass", cyc);
    chk("all_pass_latency", (cyc <= 6*(1+10+3) + 6), 1);
    check_result("all_pass");

    // Item 2 never detects, two retries
    set_all(10, M_OK, 3, 2);
    mode_a[2] = M_MISS; retry_v = 2;
    full_run("miss_retry");

    // Item 1 stuck high, stop on first fail
    set_all(10, M_OK, 3, 2);
    mode_a[1] = M_STUCK; stop_v = 1'b1;
    full_run("stuck_stop");

    // Sparse mask, zero window on item 5
    set_all(10, M_OK, 3, 2);
    mask_v = 6'b100101; win_a[5] = 0; dly_a[5] = 0; len_a[5] = 1;
    full_run("mask");

    set_all(10, M_OK, 3, 2);
    mask_v = '0;
    full_run("all_masked");

    // Abort in the middle of item 3, then restart
    set_all(10, M_OK, 3, 2);
    start_run("abort");
    k = 0;
    while (!bus.o_bist_drv[3] && k < 500) begin @(negedge clk); #1; k++; end
    chk("abort_reach_item3", bus.o_bist_drv[3], 1);
    bus.i_bist_en = 1'b0;
    @(negedge clk); #1;
    chk("abort_drv",   bus.o_bist_drv, 0);
    chk("abort_flags", {bus.o_bist_busy, bus.o_bist_done, bus.o_lbist_en}, 0);
    chk("abort_pass_kept", bus.o_bist_pass, 6'h07);
    full_run("restart");

    // Asynchronous reset during a drive pulse
    set_all(10, M_OK, 3, 2);
    start_run("areset");
    k = 0;
    while (bus.o_bist_drv == '0 && k < 100) begin @(negedge clk); #1; k++; end
    chk("areset_in_drive", (bus.o_bist_drv != '0), 1);
    #2;
    rst = 1'b1; bus.i_bist_en = 1'b0;
    #1;
    chk("areset_drv",   bus.o_bist_drv, 0);
    chk("areset_flags", {bus.o_bist_busy, bus.o_bist_done, bus.o_lbist_en}, 0);
    chk("areset_status", {bus.o_bist_pass, bus.o_bist_fail, bus.o_bist_stuck}, 0);
    chk("areset_cur",   bus.o_cur_item, 0);
    @(negedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;

    // Randomized scenarios
    for (int s = 0; s < 12; s++) begin
      for (int i = 0; i < N; i++) begin
        win_a[i] = $urandom_range(0, 12);
        dly_a[i] = $urandom_range(0, ((win_a[i] == 0) ? 1 : win_a[i]) - 1);
        len_a[i] = $urandom_range(1, 4);
        r = $urandom_range(0, 9);
        mode_a[i] = (r < 7) ? M_OK : (r < 9) ? M_MISS : M_STUCK;
      end
      mask_v  = N'($urandom);
      retry_v = $urandom_range(0, 3);
      stop_v  = 1'($urandom_range(0, 1));
      full_run($sformatf("rnd%0d", s));
    end

    chk("never_multi_hot", multi_hot, 0);
    chk("single_bit_change", multi_chg, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
